// File: rtl/fetch_sequencer.sv
// Program-counter sequencer: sequential fetch, table-driven branches, call/return stack,
// fetch stall and halt detection. All state is cleared asynchronously by the active-low reset.
module fetch_sequencer #(
    parameter int PC_W      = 12,
    parameter int LBL_W     = 8,
    parameter int TBL_DEPTH = 32,
    parameter int RAS_DEPTH = 4,
    parameter int HALT_PC   = 2000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         stall,
    input  logic                         br_taken,
    input  logic                         call,
    input  logic                         ret,
    input  logic [LBL_W-1:0]             br_label,
    input  logic                         tbl_we,
    input  logic [$clog2(TBL_DEPTH)-1:0] tbl_addr,
    input  logic [PC_W-1:0]              tbl_data,
    output logic [PC_W-1:0]              pc,
    output logic                         done,
    output logic                         ras_overflow,
    output logic                         ras_underflow
);
    localparam int TBL_AW = $clog2(TBL_DEPTH);
    localparam int RAS_AW = $clog2(RAS_DEPTH);
    localparam int CNT_W  = RAS_AW + 1;
    // A halt address outside the PC range can never be reached.
    localparam logic            HALT_OK = (HALT_PC >= 0) && (longint'(HALT_PC) < (64'd1 << PC_W));
    localparam logic [PC_W-1:0] HALT_V  = PC_W'(HALT_PC);

    logic [PC_W-1:0]   pc_q, pc_d, pc_inc, tgt;
    logic [PC_W-1:0]   tbl_q [TBL_DEPTH];
    logic [PC_W-1:0]   ras_q [RAS_DEPTH];
    logic [RAS_AW-1:0] top_q, top_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d, udf_q, udf_d;
    logic              push;
    logic              stack_empty, stack_full;

    assign pc_inc      = pc_q + PC_W'(1);
    assign tgt         = tbl_q[br_label[TBL_AW-1:0]];
    assign stack_empty = (cnt_q == '0);
    assign stack_full  = (cnt_q == CNT_W'(RAS_DEPTH));

    assign pc            = pc_q;
    assign done          = HALT_OK && (pc_q == HALT_V);
    assign ras_overflow  = ovf_q;
    assign ras_underflow = udf_q;

    always_comb begin
        pc_d  = pc_q;
        top_d = top_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        udf_d = udf_q;
        push  = 1'b0;
        if (done || stall) begin
            pc_d = pc_q;
        end else if (ret) begin
            if (stack_empty) begin
                udf_d = 1'b1;
                pc_d  = pc_inc;
            end else begin
                pc_d  = ras_q[top_q];
                top_d = top_q - RAS_AW'(1);
                cnt_d = cnt_q - CNT_W'(1);
            end
        end else if (call) begin
            // When full, the advancing top pointer lands on the oldest entry.
            push  = 1'b1;
            pc_d  = tgt;
            top_d = top_q + RAS_AW'(1);
            if (stack_full) ovf_d = 1'b1;
            else            cnt_d = cnt_q + CNT_W'(1);
        end else if (br_taken) begin
            pc_d = tgt;
        end else begin
            pc_d = pc_inc;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q  <= '0;
            top_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            top_q <= top_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    // Table writes ignore stall/done; lookups this cycle still see the old entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < TBL_DEPTH; i++) tbl_q[i] <= '0;
        end else if (tbl_we) begin
            tbl_q[tbl_addr] <= tbl_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
        end else if (push) begin
            ras_q[top_d] <= pc_inc;
        end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: sequencing, branches, call/return, stack limits,
// halt/stall, PC wrap on a 4-bit instance, and asynchronous reset.
module tb_fetch_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0, br_taken = 1'b0, call = 1'b0, ret = 1'b0;
    logic [7:0]  br_label = '0;
    logic        tbl_we = 1'b0;
    logic [4:0]  tbl_addr = '0;
    logic [11:0] tbl_data = '0;
    logic [11:0] pc;
    logic        done, ovf, udf;

    logic        reset_w = 1'b0;
    logic        zero_bit = 1'b0;
    logic [7:0]  zero_lbl = '0;
    logic [4:0]  zero_addr = '0;
    logic [3:0]  zero_data = '0;
    logic [3:0]  pc_w;
    logic        done_w, ovf_w, udf_w;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk(clk), .reset(reset), .stall(stall), .br_taken(br_taken), .call(call), .ret(ret),
        .br_label(br_label), .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
        .pc(pc), .done(done), .ras_overflow(ovf), .ras_underflow(udf)
    );

    fetch_sequencer #(.PC_W(4)) dut_w (
        .clk(clk), .reset(reset_w), .stall(zero_bit), .br_taken(zero_bit), .call(zero_bit),
        .ret(zero_bit), .br_label(zero_lbl), .tbl_we(zero_bit), .tbl_addr(zero_addr),
        .tbl_data(zero_data), .pc(pc_w), .done(done_w), .ras_overflow(ovf_w),
        .ras_underflow(udf_w)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        $display("[%0t] check %s: observed %0d expected %0d", $time, tag, obs, exp);
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ctrl(input logic s, input logic b, input logic c, input logic r,
                        input logic [7:0] lbl);
        stall = s; br_taken = b; call = c; ret = r; br_label = lbl;
        tick();
        stall = 1'b0; br_taken = 1'b0; call = 1'b0; ret = 1'b0; br_label = '0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [11:0] d);
        tbl_we = 1'b1; tbl_addr = a; tbl_data = d;
        tick();
        tbl_we = 1'b0;
    endtask

    initial begin
        // Reset and sequential fetch
        repeat (3) @(posedge clk);
        #1;
        chk("reset_pc", 32'(pc), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_ovf", 32'(ovf), 0);
        chk("reset_udf", 32'(udf), 0);
        reset = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("seq_pc", 32'(pc), i);
        end
        chk("seq_done", 32'(done), 0);

        // Branch via table, upper label bits ignored
        wr(5'd3, 12'd100);
        chk("wr_pc", 32'(pc), 6);
        ctrl(1'b0, 1'b1, 1'b0, 1'b0, 8'h23);
        chk("branch_pc", 32'(pc), 100);

        // Same-cycle write and lookup sees the old value
        tbl_we = 1'b1; tbl_addr = 5'd5; tbl_data = 12'd7;
        ctrl(1'b0, 1'b1, 1'b0, 1'b0, 8'd5);
        tbl_we = 1'b0;
        chk("wr_bypass_pc", 32'(pc), 0);
        ctrl(1'b0, 1'b1, 1'b0, 1'b0, 8'd5);
        chk("wr_landed_pc", 32'(pc), 7);

        wr(5'd10, 12'd200);
        wr(5'd11, 12'd300);
        wr(5'd12, 12'd10);
        wr(5'd13, 12'd400);
        wr(5'd14, 12'd500);
        wr(5'd15, 12'd600);
        wr(5'd16, 12'd700);
        wr(5'd17, 12'd800);
        wr(5'd18, 12'd1498);
        chk("after_writes_pc", 32'(pc), 16);
        ctrl(1'b0, 1'b1, 1'b0, 1'b0, 8'd12);
        chk("to10_pc", 32'(pc), 10);

        // Nested call/return
        ctrl(1'b0, 1'b0, 1'b1, 1'b0, 8'd10);
        chk("call1_pc", 32'(pc), 200);
        ctrl(1'b0, 1'b0, 1'b1, 1'b0, 8'd11);
        chk("call2_pc", 32'(pc), 300);
        ctrl(1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
        chk("ret1_pc", 32'(pc), 201);
        ctrl(1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
        chk("ret2_pc", 32'(pc), 11);
        chk("nest_ovf", 32'(ovf), 0);
        chk("nest_udf", 32'(udf), 0);

        // Five calls overflow a 4-deep stack; five returns underflow
        ctrl(1'b0, 1'b0, 1'b1, 1'b0, 8'd13);
        chk("c1_pc", 32'(pc), 400);
        ctrl(1'b0, 1'b0, 1'b1, 1'b0, 8'd14);
        chk("c2_pc", 32'(pc), 500);
        ctrl(1'b0, 1'b0, 1'b1, 1'b0, 8'd15);
        chk("c3_pc", 32'(pc), 600);
        ctrl(1'b0, 1'b0, 1'b1, 1'b0, 8'd16);
        chk("c4_pc", 32'(pc), 700);
        chk("c4_ovf", 32'(ovf), 0);
        ctrl(1'b0, 1'b0, 1'b1, 1'b0, 8'd17);
        chk("c5_pc", 32'(pc), 800);
        chk("c5_ovf", 32'(ovf), 1);
        ctrl(1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
        chk("r1_pc", 32'(pc), 701);
        ctrl(1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
        chk("r2_pc", 32'(pc), 601);
        ctrl(1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
        chk("r3_pc", 32'(pc), 501);
        ctrl(1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
        chk("r4_pc", 32'(pc), 401);
        chk("r4_udf", 32'(udf), 0);
        ctrl(1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
        chk("r5_pc", 32'(pc), 402);
        chk("r5_udf", 32'(udf), 1);

        // Stall at 1500, run to halt, control inputs ignored once done
        ctrl(1'b0, 1'b1, 1'b0, 1'b0, 8'd18);
        chk("to1498_pc", 32'(pc), 1498);
        tick();
        tick();
        chk("at1500_pc", 32'(pc), 1500);
        ctrl(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        chk("stall1_pc", 32'(pc), 1500);
        ctrl(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        chk("stall2_pc", 32'(pc), 1500);
        tick();
        chk("unstall_pc", 32'(pc), 1501);
        repeat (498) tick();
        chk("pre_halt_pc", 32'(pc), 1999);
        chk("pre_halt_done", 32'(done), 0);
        tick();
        chk("halt_pc", 32'(pc), 2000);
        chk("halt_done", 32'(done), 1);
        ctrl(1'b0, 1'b1, 1'b1, 1'b0, 8'd13);
        chk("halt_hold_pc", 32'(pc), 2000);
        ctrl(1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
        chk("halt_hold2_pc", 32'(pc), 2000);
        chk("halt_done2", 32'(done), 1);
        chk("halt_ovf", 32'(ovf), 1);
        chk("halt_udf", 32'(udf), 1);

        // 4-bit PC wraps 15 -> 0
        chk("w_reset_pc", 32'(pc_w), 0);
        reset_w = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            tick();
            chk("wrap_pc", 32'(pc_w), i % 16);
        end
        chk("wrap_done", 32'(done_w), 0);
        chk("wrap_ovf", 32'(ovf_w), 0);

        // Asynchronous reset between edges
        #3;
        reset = 1'b0;
        reset_w = 1'b0;
        #1;
        chk("async_pc", 32'(pc), 0);
        chk("async_done", 32'(done), 0);
        chk("async_ovf", 32'(ovf), 0);
        chk("async_udf", 32'(udf), 0);
        chk("async_w_pc", 32'(pc_w), 0);
        reset = 1'b1;
        ctrl(1'b0, 1'b1, 1'b0, 1'b0, 8'd5);
        chk("tbl_cleared5_pc", 32'(pc), 0);
        ctrl(1'b0, 1'b1, 1'b0, 1'b0, 8'd3);
        chk("tbl_cleared3_pc", 32'(pc), 0);
        tick();
        chk("post_reset_seq_pc", 32'(pc), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Parametrised program-counter and control-flow sequencer for the next-generation single-cycle core. It replaces the fixed 12-bit PC register, the `pc + 1` adder, the branch-label lookup and the hard-wired halt compare. It adds a writable branch-target table, a return-address stack for call/return, a fetch stall and sticky stack-error flags. The instruction ROM is addressed directly by `pc`. The decoder and ALU drive the control inputs in the same cycle.

## Interface
- `PC_W`, 12, PC and target width
- `LBL_W`, 8, branch label width as read from the register file
- `TBL_DEPTH`, 32, target table entries (power of two); indexed by `br_label[$clog2(TBL_DEPTH)-1:0]`
- `RAS_DEPTH`, 4, return-address stack entries (power of two, ≥2)
- `HALT_PC`, 2000, PC value that ends execution

Ports:
- `clk` in 1: the single clock; all state changes on its rising edge
- `reset` in 1: asynchronous, active-low; asserted (0) clears all state immediately
- `stall` in 1: hold PC; stack and flags untouched
- `br_taken` in 1: conditional branch resolved taken (branch && zero)
- `call` in 1: subroutine call
- `ret` in 1: subroutine return
- `br_label` in LBL_W: label selecting the target-table entry for branch/call
- `tbl_we` in 1: target-table write enable
- `tbl_addr` in $clog2(TBL_DEPTH): table write index
- `tbl_data` in PC_W: table write data
- `pc` out PC_W: current fetch address (registered)
- `done` out 1: `pc == HALT_PC` (combinational from `pc`)
- `ras_overflow` out 1: sticky; a push occurred while the stack was full
- `ras_underflow` out 1: sticky; a pop occurred while the stack was empty

## Operation
- Next-PC priority, evaluated every cycle:
  1. `done` high: hold PC; all control inputs ignored.
  2. `stall`: hold PC.
  3. `ret`: pop the stack and load the popped value into PC. If the stack is empty, set `ras_underflow` and load `pc + 1`.
  4. `call`: push `pc + 1` and load `table[br_label]` into PC.
  5. `br_taken`: load `table[br_label]` into PC.
  6. Otherwise: load `pc + 1`.
- `pc + 1` wraps modulo 2^PC_W; wrapping from all-ones to 0 is legal and unflagged.
- `br_label` bits above the table index are ignored.
- Stack:
  - Circular buffer with a top pointer and an occupancy count from 0 to RAS_DEPTH.
  - Push when full overwrites the oldest entry, keeps the count at RAS_DEPTH and sets `ras_overflow`.
  - Pop decrements the count.
- `call` and `ret` in the same cycle: `ret` wins and no push occurs.
- Stacked addresses are PC_W wide. Wrap of `pc + 1` is stored as-is.
- Target table:
  - TBL_DEPTH × PC_W registers.
  - A write lands on the clock edge; the new value is visible to lookups from the next cycle.
  - A same-cycle lookup of the entry being written returns the old value.
  - Writes are accepted regardless of `stall` and `done`.
- Sticky flags clear only on reset.

## Timing
- Reset values (while `reset`=0 and after release): `pc`=0, stack count 0, all table entries 0, `ras_overflow`=0, `ras_underflow`=0.
- `done` is 1 only if HALT_PC is 0.
- First rising edge with `reset`=1 produces `pc`=1, unless `stall`, `done` or a control input is active.
- Latency: control inputs sampled at edge N determine `pc` after edge N; there are no bubbles.
- `done` rises in the same cycle `pc` reaches HALT_PC and stays high until reset.
- Reset mid-operation clears PC, stack, flags and table immediately, independent of `clk`.

## Test plan
- Reset/sequential: hold reset low for 3 cycles, then release with no inputs for 5 edges. Required: `pc` = 0, 1, 2, 3, 4, 5; `done`=0.
- Branch and table: write table[3]=100, then assert `br_taken` with `br_label`=8'h23 (TBL_DEPTH 32) for one cycle. Required: `pc`=100 next cycle. In a separate step, write table[5]=7 while branching via label 5 in the same cycle. Required: `pc`=0, the old entry value.
- Call/return nesting: at pc=10 call label→200; at pc=200 call label→300; ret; ret. Required: `pc` = 200, 300, 201, 11; no flags set.
- Stack boundaries (RAS_DEPTH=4): make 5 calls, then 5 rets. Required: `ras_overflow`=1 after the 5th call; the first 4 rets return the 4 newest addresses; the 5th ret sets `ras_underflow`=1 and advances `pc + 1`.
- Halt and stall: drive sequentially to HALT_PC=2000 with a 2-cycle stall at pc=1500. Required: `pc` holds 1500 for 2 cycles; `done`=1 when `pc`=2000; `pc` stays 2000 despite `br_taken`/`call`.
- Wrap and async reset: set PC_W=4 and run 17 edges from 0. Required: `pc` wraps 15→0. Then drop `reset` between clock edges. Required: `pc`=0 and flags=0 without waiting for an edge.
